// File: rtl/fft_pingpong_ctrl_if.sv
// rtl/fft_pingpong_ctrl_if.sv - block-level handshake and stage-engine signals of the ping-pong FFT controller
interface fft_pingpong_ctrl_if #(
    parameter int STAGE_W = 4
);
    logic               ap_start;
    logic               ap_continue;
    logic               ap_done;
    logic               ap_idle;
    logic               ap_ready;
    logic               stage_start;
    logic               stage_done;
    logic               stage_continue;
    logic [STAGE_W-1:0] stage_idx;
    logic               rd_bank;
    logic               wr_bank;
    logic               result_bank;
    logic [15:0]        frame_cnt;

    // Controller view: takes frame requests and stage completions, drives everything else
    modport slave (
        input  ap_start, ap_continue, stage_done,
        output ap_done, ap_idle, ap_ready, stage_start, stage_continue,
        output stage_idx, rd_bank, wr_bank, result_bank, frame_cnt
    );

    // Environment view: requester plus stage engine
    modport master (
        output ap_start, ap_continue, stage_done,
        input  ap_done, ap_idle, ap_ready, stage_start, stage_continue,
        input  stage_idx, rd_bank, wr_bank, result_bank, frame_cnt
    );
endinterface

// File: rtl/fft_pingpong_ctrl.sv
// rtl/fft_pingpong_ctrl.sv - sequences NUM_STAGES radix-2 passes over two ping-pong banks per frame
module fft_pingpong_ctrl #(
    parameter int NUM_STAGES = 10,
    parameter int STAGE_W    = 4
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    fft_pingpong_ctrl_if.slave ctrl
);
    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        LAUNCH = 3'b010,
        RUN    = 3'b100
    } state_t;

    localparam logic [STAGE_W-1:0] LAST_IDX = STAGE_W'(NUM_STAGES - 1);
    localparam logic [STAGE_W-1:0] IDX_ONE  = STAGE_W'(1);

    state_t             state_q, state_d;
    logic [STAGE_W-1:0] stage_idx_q, stage_idx_d;
    logic               rd_bank_q, rd_bank_d;
    logic               result_bank_q, result_bank_d;
    logic               done_reg_q, done_reg_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    logic               stage_start_c;
    logic               stage_continue_c;
    logic               ap_done_c;
    logic               ap_ready_c;
    logic               ap_idle_c;

    // State and datapath registers; reset abandons any frame in flight
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q       <= IDLE;
            stage_idx_q   <= '0;
            rd_bank_q     <= 1'b0;
            result_bank_q <= 1'b0;
            done_reg_q    <= 1'b0;
            frame_cnt_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            stage_idx_q   <= stage_idx_d;
            rd_bank_q     <= rd_bank_d;
            result_bank_q <= result_bank_d;
            done_reg_q    <= done_reg_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    // Next-state and handshake decode; the last stage's completion is reported in its own cycle
    always_comb begin
        state_d          = state_q;
        stage_idx_d      = stage_idx_q;
        rd_bank_d        = rd_bank_q;
        result_bank_d    = result_bank_q;
        frame_cnt_d      = frame_cnt_q;
        done_reg_d       = done_reg_q & ~ctrl.ap_continue;
        stage_start_c    = 1'b0;
        stage_continue_c = 1'b0;
        ap_done_c        = done_reg_q;
        ap_ready_c       = 1'b0;
        ap_idle_c        = 1'b0;

        unique case (state_q)
            IDLE: begin
                ap_idle_c = ~ctrl.ap_start;
                // An unacknowledged ap_done holds off the next frame
                if (ctrl.ap_start && !done_reg_q) begin
                    state_d     = LAUNCH;
                    stage_idx_d = '0;
                    rd_bank_d   = 1'b0;
                end
            end
            LAUNCH: begin
                // stage_done seen here belongs to nothing we launched, so it is ignored
                stage_start_c = 1'b1;
                state_d       = RUN;
            end
            RUN: begin
                stage_continue_c = ctrl.stage_done;
                if (ctrl.stage_done) begin
                    if (stage_idx_q == LAST_IDX) begin
                        ap_done_c     = 1'b1;
                        ap_ready_c    = 1'b1;
                        result_bank_d = ~rd_bank_q;
                        frame_cnt_d   = frame_cnt_q + 16'd1;
                        done_reg_d    = ~ctrl.ap_continue;
                        state_d       = IDLE;
                    end else begin
                        stage_idx_d = stage_idx_q + IDX_ONE;
                        rd_bank_d   = ~rd_bank_q;
                        state_d     = LAUNCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ctrl.stage_start    = stage_start_c;
    assign ctrl.stage_continue = stage_continue_c;
    assign ctrl.ap_done        = ap_done_c;
    assign ctrl.ap_ready       = ap_ready_c;
    assign ctrl.ap_idle        = ap_idle_c;
    assign ctrl.stage_idx      = stage_idx_q;
    assign ctrl.rd_bank        = rd_bank_q;
    assign ctrl.wr_bank        = ~rd_bank_q;
    assign ctrl.result_bank    = result_bank_q;
    assign ctrl.frame_cnt      = frame_cnt_q;
endmodule

// File: tb/tb_fft_pingpong_ctrl.sv
// tb/tb_fft_pingpong_ctrl.sv - scoreboard bench for fft_pingpong_ctrl with 10-stage and 1-stage instances
module tb_fft_pingpong_ctrl;
    typedef struct packed {
        logic [3:0] idx;
        logic       rd;
    } launch_t;

    typedef struct packed {
        int         cyc;
        logic       rb;
        logic [15:0] fc;
    } done_t;

    typedef struct packed {
        logic        ss, sc, sd, dn, idle, rdy, rd, wr, rb;
        logic [3:0]  idx;
        logic [15:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    bit          hold_done [2];
    logic [15:0] model_fc  [2];
    launch_t     launch_q  [2][$];
    done_t       done_q    [2][$];
    int          wait_q    [2][$];
    bit          pend      [2];
    logic        exp_rb    [2];
    logic [15:0] exp_fc    [2];

    fft_pingpong_ctrl_if #(.STAGE_W(4)) bus_a ();
    fft_pingpong_ctrl_if #(.STAGE_W(4)) bus_b ();

    fft_pingpong_ctrl #(.NUM_STAGES(10), .STAGE_W(4)) dut_a (
        .ap_clk (clk),
        .ap_rst (rst_a),
        .ctrl   (bus_a)
    );

    fft_pingpong_ctrl #(.NUM_STAGES(1), .STAGE_W(4)) dut_b (
        .ap_clk (clk),
        .ap_rst (rst_b),
        .ctrl   (bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic obs_t sample(input int g);
        obs_t o;
        if (g == 0) begin
            o.ss = bus_a.stage_start;  o.sc = bus_a.stage_continue; o.sd = bus_a.stage_done;
            o.dn = bus_a.ap_done;      o.idle = bus_a.ap_idle;      o.rdy = bus_a.ap_ready;
            o.rd = bus_a.rd_bank;      o.wr = bus_a.wr_bank;        o.rb = bus_a.result_bank;
            o.idx = bus_a.stage_idx;   o.fc = bus_a.frame_cnt;
        end else begin
            o.ss = bus_b.stage_start;  o.sc = bus_b.stage_continue; o.sd = bus_b.stage_done;
            o.dn = bus_b.ap_done;      o.idle = bus_b.ap_idle;      o.rdy = bus_b.ap_ready;
            o.rd = bus_b.rd_bank;      o.wr = bus_b.wr_bank;        o.rb = bus_b.result_bank;
            o.idx = bus_b.stage_idx;   o.fc = bus_b.frame_cnt;
        end
        return o;
    endfunction

    task automatic set_start(input int g, input logic v);
        if (g == 0) bus_a.ap_start = v; else bus_b.ap_start = v;
    endtask

    task automatic set_cont(input int g, input logic v);
        if (g == 0) bus_a.ap_continue = v; else bus_b.ap_continue = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a frame accepted at the end of cycle c runs stage k for 2+w_k cycles,
    // reads bank k mod 2, and leaves its result in the bank opposite the last read bank.
    task automatic expect_frame(input int g, input int c, input int fw, output int dcyc);
        int      n;
        int      t;
        int      w;
        launch_t l;
        done_t   d;
        n = (g == 0) ? 10 : 1;
        t = c;
        for (int k = 0; k < n; k++) begin
            w = (fw >= 0) ? fw : int'($urandom_range(0, 4));
            wait_q[g].push_back(w);
            l.idx = 4'(k);
            l.rd  = (k % 2) == 1;
            launch_q[g].push_back(l);
            t += 2 + w;
        end
        model_fc[g] = model_fc[g] + 16'd1;
        d.cyc = t;
        d.rb  = (n % 2) == 1;
        d.fc  = model_fc[g];
        done_q[g].push_back(d);
        dcyc = t;
    endtask

    task automatic wait_drain(input int g, input int budget);
        int n;
        n = 0;
        while ((done_q[g].size() != 0 || pend[g]) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_outstanding", done_q[g].size() + int'(pend[g]), 0);
        #1;
    endtask

    task automatic wait_until(input int target);
        int n;
        n = 0;
        while (cyc < target && n < 2000) begin
            tick();
            n++;
        end
    endtask

    // Stage engine model: answers each stage_start after a queued number of wait cycles,
    // or holds stage_done high continuously when hold_done is set
    initial begin : engine
        int   cnt [2];
        logic v;
        obs_t o;
        cnt[0] = 0;
        cnt[1] = 0;
        bus_a.stage_done = 1'b0;
        bus_b.stage_done = 1'b0;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                o = sample(g);
                if (o.ss) cnt[g] = (wait_q[g].size() != 0 ? wait_q[g].pop_front() : 0) + 1;
            end
            @(posedge clk);
            #1;
            for (int g = 0; g < 2; g++) begin
                v = 1'b0;
                if (hold_done[g]) begin
                    v = 1'b1;
                    cnt[g] = 0;
                end else if (cnt[g] > 0) begin
                    cnt[g]--;
                    v = (cnt[g] == 0);
                end
                if (g == 0) bus_a.stage_done = v; else bus_b.stage_done = v;
            end
        end
    end

    // Monitor: pops expectations whenever a DUT launches a stage or reports completion
    initial begin : monitor
        obs_t    o;
        launch_t l;
        done_t   d;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                o = sample(g);
                if (pend[g]) begin
                    chk("result_bank", int'(o.rb), int'(exp_rb[g]));
                    chk("frame_cnt", int'(o.fc), int'(exp_fc[g]));
                    pend[g] = 1'b0;
                end
                chk("wr_bank_opposite_rd_bank", int'(o.wr), int'(!o.rd));
                if (!o.sd) chk("stage_continue_without_done", int'(o.sc), 0);
                if (o.ss) begin
                    chk("stage_continue_in_launch", int'(o.sc), 0);
                    if (launch_q[g].size() == 0) begin
                        chk("unexpected_stage_start", int'(o.idx), -1);
                    end else begin
                        l = launch_q[g].pop_front();
                        chk("stage_idx", int'(o.idx), int'(l.idx));
                        chk("rd_bank", int'(o.rd), int'(l.rd));
                    end
                end
                if (o.rdy) begin
                    chk("ap_done_with_ready", int'(o.dn), 1);
                    chk("stage_continue_with_ready", int'(o.sc), 1);
                    if (done_q[g].size() == 0) begin
                        chk("unexpected_ap_ready", cyc, -1);
                    end else begin
                        d = done_q[g].pop_front();
                        chk("done_cycle", cyc, d.cyc);
                        pend[g]   = 1'b1;
                        exp_rb[g] = d.rb;
                        exp_fc[g] = d.fc;
                    end
                end
            end
        end
    end

    initial begin : stim
        int   c;
        int   d;
        int   p;
        bit   seen;
        obs_t o;

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.ap_start = 1'b0; bus_a.ap_continue = 1'b0;
        bus_b.ap_start = 1'b0; bus_b.ap_continue = 1'b0;
        hold_done[0] = 1'b0; hold_done[1] = 1'b0;
        model_fc[0] = 16'd0; model_fc[1] = 16'd0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Post-reset state of both instances
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            o = sample(g);
            chk("rst_stage_start", int'(o.ss), 0);
            chk("rst_stage_continue", int'(o.sc), 0);
            chk("rst_ap_done", int'(o.dn), 0);
            chk("rst_ap_ready", int'(o.rdy), 0);
            chk("rst_ap_idle", int'(o.idle), 1);
            chk("rst_stage_idx", int'(o.idx), 0);
            chk("rst_rd_bank", int'(o.rd), 0);
            chk("rst_result_bank", int'(o.rb), 0);
            chk("rst_frame_cnt", int'(o.fc), 0);
        end

        // Single pulse, fixed 3-cycle stage waits: done lands 50 cycles after acceptance
        tick();
        set_cont(0, 1'b1);
        c = cyc;
        expect_frame(0, c, 3, d);
        set_start(0, 1'b1);
        tick();
        set_start(0, 1'b0);
        wait_drain(0, 200);

        // Random waits, separate pulses with random gaps
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            c = cyc;
            expect_frame(0, c, -1, d);
            set_start(0, 1'b1);
            tick();
            set_start(0, 1'b0);
            wait_drain(0, 300);
        end

        // Back-to-back frames with ap_start held and ap_continue high
        set_start(0, 1'b1);
        c = cyc;
        for (int i = 0; i < 3; i++) begin
            expect_frame(0, c, -1, d);
            c = d + 1;
        end
        wait_until(d + 1);
        set_start(0, 1'b0);
        wait_drain(0, 300);

        // ap_continue low at completion: ap_done holds and no new frame starts until acknowledged
        set_cont(0, 1'b0);
        c = cyc;
        expect_frame(0, c, -1, d);
        set_start(0, 1'b1);
        wait_until(d + 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            o = sample(0);
            chk("ap_done_held", int'(o.dn), 1);
            chk("no_launch_while_done", int'(o.ss), 0);
            chk("ap_idle_while_blocked", int'(o.idle), 0);
            tick();
        end
        set_cont(0, 1'b1);
        p = cyc;
        expect_frame(0, p + 1, -1, d);
        @(negedge clk);
        o = sample(0);
        chk("ap_done_in_continue_cycle", int'(o.dn), 1);
        tick();
        set_cont(0, 1'b0);
        @(negedge clk);
        o = sample(0);
        chk("ap_done_after_continue", int'(o.dn), 0);
        wait_until(d + 1);
        set_start(0, 1'b0);
        set_cont(0, 1'b1);
        wait_drain(0, 300);

        // stage_done held high throughout, including every LAUNCH cycle
        hold_done[0] = 1'b1;
        repeat (3) tick();
        c = cyc;
        expect_frame(0, c, 0, d);
        set_start(0, 1'b1);
        tick();
        set_start(0, 1'b0);
        wait_drain(0, 200);
        hold_done[0] = 1'b0;
        repeat (3) tick();

        // Reset in the RUN phase of stage 5
        c = cyc;
        expect_frame(0, c, -1, d);
        set_start(0, 1'b1);
        tick();
        set_start(0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus_a.stage_start && bus_a.stage_idx == 4'd5) seen = 1'b1;
        end
        chk("reached_stage5", int'(seen), 1);
        tick();
        rst_a = 1'b1;
        launch_q[0].delete();
        done_q[0].delete();
        wait_q[0].delete();
        model_fc[0] = 16'd0;
        tick();
        rst_a = 1'b0;
        @(negedge clk);
        o = sample(0);
        chk("midrst_ap_idle", int'(o.idle), 1);
        chk("midrst_stage_idx", int'(o.idx), 0);
        chk("midrst_rd_bank", int'(o.rd), 0);
        chk("midrst_frame_cnt", int'(o.fc), 0);
        chk("midrst_stage_start", int'(o.ss), 0);
        chk("midrst_stage_continue", int'(o.sc), 0);
        chk("midrst_ap_done", int'(o.dn), 0);
        repeat (8) tick();

        // frame_cnt wrap from 0xFFFF
        force dut_a.frame_cnt_q = 16'hFFFF;
        model_fc[0] = 16'hFFFF;
        tick();
        tick();
        release dut_a.frame_cnt_q;
        @(negedge clk);
        o = sample(0);
        chk("frame_cnt_preload", int'(o.fc), 65535);
        tick();
        c = cyc;
        expect_frame(0, c, -1, d);
        set_start(0, 1'b1);
        tick();
        set_start(0, 1'b0);
        wait_drain(0, 300);

        // Single-stage instance: one launch, no bank toggle, result in bank 1
        set_cont(1, 1'b1);
        c = cyc;
        expect_frame(1, c, 0, d);
        set_start(1, 1'b1);
        tick();
        set_start(1, 1'b0);
        wait_drain(1, 50);
        set_start(1, 1'b1);
        c = cyc;
        for (int i = 0; i < 4; i++) begin
            expect_frame(1, c, -1, d);
            c = d + 1;
        end
        wait_until(d + 1);
        set_start(1, 1'b0);
        wait_drain(1, 200);

        repeat (5) tick();
        for (int g = 0; g < 2; g++) begin
            chk("launch_queue_empty", launch_q[g].size(), 0);
            chk("done_queue_empty", done_q[g].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_pingpong_ctrl.md
FFT_PINGPONG_CTRL -- requirements
Module: fft_pingpong_ctrl

Interface
REQ-001 The module SHALL expose parameter NUM_STAGES, default 10, meaning the number of radix-2 stage invocations per frame (range 1..15).
REQ-002 The module SHALL expose parameter STAGE_W, default 4, meaning the width of stage_idx.
REQ-003 The module SHALL use one clock, ap_clk; reset ap_rst SHALL be synchronous and active-high.
REQ-004 The module SHALL have port ap_clk, input, 1 bit, meaning the block clock.
REQ-005 The module SHALL have port ap_rst, input, 1 bit, meaning synchronous active-high reset.
REQ-006 The module SHALL have port ap_start, input, 1 bit, meaning a frame request.
REQ-007 The module SHALL have port ap_continue, input, 1 bit, meaning the consumer acknowledges ap_done.
REQ-008 The module SHALL have ports ap_done, ap_idle and ap_ready, each output, 1 bit, with block-level ap_ctrl_chain meaning.
REQ-009 The module SHALL have port stage_start, output, 1 bit, meaning the start pulse to the shared stage engine.
REQ-010 The module SHALL have port stage_done, input, 1 bit, meaning the stage engine's ap_done.
REQ-011 The module SHALL have port stage_continue, output, 1 bit, meaning the acknowledge to the stage engine.
REQ-012 The module SHALL have port stage_idx, output, STAGE_W bits, meaning the current stage number.
REQ-013 The module SHALL have ports rd_bank and wr_bank, each output, 1 bit, meaning the ping-pong bank the stage reads from and the bank it writes to.
REQ-014 The module SHALL have port result_bank, output, 1 bit, meaning the bank that holds the last completed frame.
REQ-015 The module SHALL have port frame_cnt, output, 16 bits, meaning the count of completed frames.

Function
REQ-016 The FSM SHALL be one-hot with three states: IDLE, LAUNCH and RUN.
REQ-017 In IDLE, the FSM SHALL go to LAUNCH when ap_start=1 and done_reg=0, loading stage_idx<=0 and rd_bank<=0; otherwise it SHALL stay in IDLE.
REQ-018 In IDLE, ap_idle SHALL be 1 when ap_start=0 and 0 otherwise; ap_idle SHALL be 0 in every other state.
REQ-019 In LAUNCH, stage_start SHALL be 1 for exactly that one cycle, after which the FSM SHALL go to RUN unconditionally.
REQ-020 In LAUNCH, a stage_done input SHALL be ignored.
REQ-021 In RUN, the FSM SHALL stay while stage_done=0 and keep stage_start=0.
REQ-022 In RUN, stage_continue SHALL equal stage_done (combinational, same cycle); stage_continue SHALL be 0 in all other states.
REQ-023 In RUN with stage_done=1 and stage_idx<NUM_STAGES-1, the block SHALL set stage_idx<=stage_idx+1, toggle rd_bank, and go to LAUNCH.
REQ-024 In RUN with stage_done=1 and stage_idx==NUM_STAGES-1 (the last stage), the block SHALL, in that same cycle, drive ap_done=1 and ap_ready=1 combinationally.
REQ-025 On the last stage of REQ-024, the block SHALL, at the next edge, set result_bank<=~rd_bank, increment frame_cnt (mod 2^16, 0xFFFF wraps to 0), and go to IDLE.
REQ-026 The transition of REQ-024 SHALL also set done_reg<=1 unless ap_continue=1 in that cycle.
REQ-027 Outside the cycle of REQ-024, ap_done SHALL equal done_reg, and done_reg SHALL clear on any cycle in which ap_continue=1.
REQ-028 ap_ready SHALL be 1 only in the cycle of REQ-024.
REQ-029 wr_bank SHALL always equal ~rd_bank.
REQ-030 stage_idx and rd_bank SHALL change only on the transitions of REQ-017 and REQ-023.
REQ-031 The latency from accepted ap_start to ap_done SHALL be the sum over all stages of (2 + that stage's stage_done wait cycles).
REQ-032 With NUM_STAGES=1, the block SHALL make one LAUNCH and one RUN and no toggle, so result_bank=1.

Reset
REQ-033 When ap_rst=1 at an edge, the block SHALL set state<=IDLE, stage_idx<=0, rd_bank<=0, result_bank<=0, frame_cnt<=0 and done_reg<=0, from any state including mid-frame.
REQ-034 Reset SHALL NOT generate stage_continue.
REQ-035 In the cycle after reset, stage_start, stage_continue, ap_done and ap_ready SHALL be 0, and ap_idle SHALL equal ~ap_start.

Verification
REQ-036 Bench SHALL cover: NUM_STAGES=10, ap_start pulse, stage_done 3 cycles after each stage_start -> 10 stage_start pulses, stage_idx 0..9, rd_bank 0,1,0,...,1; ap_done at cycle 50 after start; result_bank=0; frame_cnt=1.
REQ-037 Bench SHALL cover: ap_continue=0 after completion with ap_start held 1 -> no new LAUNCH and ap_done stays 1; when ap_continue pulses, ap_done drops the next cycle and the next frame starts.
REQ-038 Bench SHALL cover: stage_done forced 1 during LAUNCH -> ignored, stage_idx unchanged until a RUN-cycle stage_done.
REQ-039 Bench SHALL cover: ap_rst asserted in RUN at stage_idx=5 -> next cycle IDLE with stage_idx=0, rd_bank=0, frame_cnt=0, and no stage_start.
REQ-040 Bench SHALL cover: frame_cnt preloaded to 0xFFFF by running 65535 frames, or by a force, then one more frame -> frame_cnt=0.
REQ-041 Bench SHALL cover: NUM_STAGES=1 -> one stage_start, ap_ready=1 in the stage_done cycle, and result_bank=1.
